miriscv_dmem_arbiter: RTL and testbench

//  Shares one data-RAM port (req/we/be/addr/wdata in, rvalid/rdata out, one

---
 rtl/miriscv_dmem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_miriscv_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_dmem_arbiter.sv
// miriscv_dmem_arbiter
// Two-master arbiter for one data-RAM port. m0 is the core LSU and m1 is the
// DMA/debug master. The block grants at most one request per cycle and keeps
// an in-order FIFO of owners for the requests the RAM has accepted. Each RAM
// response goes back to the master that owns the FIFO head, one cycle later.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// contention. Without it, m0 always wins contention (fixed priority).
module miriscv_dmem_arbiter #(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_be_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_be_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [3:0]        s_be_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [31:0]       s_wdata_o,
    input  logic              s_gnt_i,
    input  logic              s_rvalid_i,
    input  logic [31:0]       s_rdata_i,
    output logic              err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // Owner FIFO pointer advance, wrapping at MAX_OUTST entries.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Owner FIFO: a 0 entry means m0, a 1 entry means m1.
    logic [MAX_OUTST-1:0] r_owner;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_m0_rvalid;
    logic                 r_m1_rvalid;
    logic [31:0]          r_m0_rdata;
    logic [31:0]          r_m1_rdata;
    logic                 r_err;
`ifdef ARB_ROUND_ROBIN_EN
    logic                 r_last_m1;   // 1: the most recent grant went to m1
`endif

    logic w_full;
    logic w_full_eff;
    logic w_empty;
    logic w_elig0;
    logic w_elig1;
    logic w_sel;                       // selected master, 0 = m0, 1 = m1
    logic w_push;
    logic w_pop;
    logic w_head;

    // Eligibility and winner selection. A response that arrives while the FIFO
    // is full frees a slot in the same cycle, so a grant is still allowed.
    always_comb begin
        w_full     = (r_count == CNT_W'(MAX_OUTST));
        w_empty    = (r_count == CNT_W'(0));
        w_full_eff = w_full & ~s_rvalid_i;
        w_elig0    = m0_req_i & ~w_full_eff;
        w_elig1    = m1_req_i & ~w_full_eff;
        w_sel      = 1'b0;
        if (w_elig0 & w_elig1) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_sel = ~r_last_m1;
`else
            w_sel = 1'b0;
`endif
        end else if (w_elig1) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
    end

    // Request path mux, forced to zero while reset is asserted.
    assign s_req_o   = arstn_i & (w_elig0 | w_elig1);
    assign s_we_o    = arstn_i & (w_sel ? m1_we_i : m0_we_i);
    assign s_be_o    = {4{arstn_i}} & (w_sel ? m1_be_i : m0_be_i);
    assign s_addr_o  = {ADDR_W{arstn_i}} & (w_sel ? m1_addr_i : m0_addr_i);
    assign s_wdata_o = {32{arstn_i}} & (w_sel ? m1_wdata_i : m0_wdata_i);

    assign w_push   = s_req_o & s_gnt_i;
    assign w_pop    = s_rvalid_i & ~w_empty;
    assign w_head   = r_owner[r_rptr];
    assign m0_gnt_o = w_push & ~w_sel;
    assign m1_gnt_o = w_push & w_sel;

    // Owner FIFO: push the winner on grant, pop the head on each response.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_owner <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_sel;
                r_wptr          <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Response routing: valid for one cycle, data held until the next response.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= 32'h0;
            r_m1_rdata  <= 32'h0;
        end else begin
            r_m0_rvalid <= w_pop & ~w_head;
            r_m1_rvalid <= w_pop & w_head;
            if (w_pop & ~w_head) begin
                r_m0_rdata <= s_rdata_i;
            end
            if (w_pop & w_head) begin
                r_m1_rdata <= s_rdata_i;
            end
        end
    end

    // Sticky error: a RAM response arrived with no outstanding owner.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_err <= 1'b0;
        end else if (s_rvalid_i & w_empty) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the most recent grant winner; starts as "m1 last".
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_last_m1 <= 1'b1;
        end else if (w_push) begin
            r_last_m1 <= w_sel;
        end else begin
            r_last_m1 <= r_last_m1;
        end
    end
`endif

    assign m0_rvalid_o = r_m0_rvalid;
    assign m1_rvalid_o = r_m1_rvalid;
    assign m0_rdata_o  = r_m0_rdata;
    assign m1_rdata_o  = r_m1_rdata;
    assign err_o       = r_err;

endmodule

// File: tb/tb_miriscv_dmem_arbiter.sv
// Testbench for miriscv_dmem_arbiter. It uses a behavioural 1-cycle RAM,
// per-master request queues and per-master expected-response scoreboards.
// It also keeps a reference model of grant, occupancy and error behaviour.
// Build with or without ARB_ROUND_ROBIN_EN, matching the RTL.
module tb_miriscv_dmem_arbiter;

    localparam int MAXO = 2;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i, err_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;

    always #5 clk_i = ~clk_i;

    miriscv_dmem_arbiter #(.MAX_OUTST(MAXO), .ADDR_W(32)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .err_o(err_o)
    );

    txn_t        q0[$], q1[$];
    logic [31:0] sb0[$], sb1[$];
    logic [31:0] pend[$];
    logic [31:0] ram_mem [0:63];
    logic [31:0] ref_mem [0:63];
    int          order[$];
    int          total = 0;
    int          bad   = 0;
    int          mcnt;
    logic        mlast, merr;
    logic [31:0] last0, last1, rd0_last;
    int          rv1_cnt;
    logic        stall, inject;

    // Count one comparison and report it when actual differs from expected.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic drive_inputs();
        m0_req_i   = (q0.size() > 0);
        m0_we_i    = (q0.size() > 0) ? q0[0].we    : 1'b0;
        m0_be_i    = (q0.size() > 0) ? q0[0].be    : 4'h0;
        m0_addr_i  = (q0.size() > 0) ? q0[0].addr  : 32'h0;
        m0_wdata_i = (q0.size() > 0) ? q0[0].wdata : 32'h0;
        m1_req_i   = (q1.size() > 0);
        m1_we_i    = (q1.size() > 0) ? q1[0].we    : 1'b0;
        m1_be_i    = (q1.size() > 0) ? q1[0].be    : 4'h0;
        m1_addr_i  = (q1.size() > 0) ? q1[0].addr  : 32'h0;
        m1_wdata_i = (q1.size() > 0) ? q1[0].wdata : 32'h0;
        s_rvalid_i = inject | (~stall & (pend.size() > 0));
        s_rdata_i  = (pend.size() > 0) ? pend[0] : 32'hDEAD_BEEF;
    endtask

    // One clock: check the request side at negedge, then the response side after posedge.
    task automatic cycle();
        logic eg0, eg1, fe, sel, acc, rv, pop, g;
        logic a_we;
        logic [3:0] a_be;
        logic [31:0] a_addr, a_wd, e;
        logic [5:0] idx;
        txn_t t;
        @(negedge clk_i);
        fe  = (mcnt == MAXO) && !s_rvalid_i;
        eg0 = m0_req_i && !fe;
        eg1 = m1_req_i && !fe;
        if (eg0 && eg1) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel = ~mlast;
`else
            sel = 1'b0;
`endif
        end else begin
            sel = eg1;
        end
        g = (eg0 | eg1) & s_gnt_i;
        check_val("s_req",  32'(s_req_o),  32'(eg0 | eg1));
        check_val("m0_gnt", 32'(m0_gnt_o), 32'(g & ~sel));
        check_val("m1_gnt", 32'(m1_gnt_o), 32'(g & sel));
        check_val("err",    32'(err_o),    32'(merr));
        if (m0_gnt_o) order.push_back(0);
        if (m1_gnt_o) order.push_back(1);
        acc = s_req_o & s_gnt_i;
        a_we = s_we_o; a_be = s_be_o; a_addr = s_addr_o; a_wd = s_wdata_o;
        rv  = s_rvalid_i;
        pop = rv && (mcnt > 0);
        if (rv && mcnt == 0) merr = 1'b1;
        if (g) begin
            if (sel) t = q1.pop_front(); else t = q0.pop_front();
            check_val("s_addr", s_addr_o, t.addr);
            idx = t.addr[7:2];
            if (t.we) begin
                ref_mem[idx] = be_merge(ref_mem[idx], t.wdata, t.be);
                e = 32'h0;
            end else begin
                e = ref_mem[idx];
            end
            if (sel) sb1.push_back(e); else sb0.push_back(e);
            mlast = sel;
        end
        mcnt = mcnt + (g ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk_i);
        #1;
        if (rv && pend.size() > 0) pend.delete(0);
        if (acc) begin
            idx = a_addr[7:2];
            if (a_we) begin
                ram_mem[idx] = be_merge(ram_mem[idx], a_wd, a_be);
                pend.push_back(32'h0);
            end else begin
                pend.push_back(ram_mem[idx]);
            end
        end
        if (m0_rvalid_o && sb0.size() == 0) begin
            check_val("m0_rvalid_unexp", 32'(m0_rvalid_o), 32'h0);
        end else if (m0_rvalid_o) begin
            e = sb0.pop_front();
            check_val("m0_rdata", m0_rdata_o, e);
            last0 = e;
            rd0_last = m0_rdata_o;
        end else begin
            check_val("m0_rdata_hold", m0_rdata_o, last0);
        end
        if (m1_rvalid_o && sb1.size() == 0) begin
            check_val("m1_rvalid_unexp", 32'(m1_rvalid_o), 32'h0);
        end else if (m1_rvalid_o) begin
            e = sb1.pop_front();
            check_val("m1_rdata", m1_rdata_o, e);
            last1 = e;
            rv1_cnt++;
        end else begin
            check_val("m1_rdata_hold", m1_rdata_o, last1);
        end
        drive_inputs();
    endtask

    // Run until every request is granted and answered, within a cycle budget.
    task automatic drain();
        for (int i = 0; i < 60 && (q0.size() + q1.size() + sb0.size() + sb1.size()) > 0; i++)
            cycle();
        check_val("drain_q",  32'(q0.size() + q1.size()), 32'h0);
        check_val("drain_sb", 32'(sb0.size() + sb1.size()), 32'h0);
    endtask

    task automatic do_reset(input bit chk);
        @(posedge clk_i);
        #1;
        arstn_i = 1'b0;
        #1;
        if (chk) begin
            check_val("rst_s_req",  32'(s_req_o),     32'h0);
            check_val("rst_m0_gnt", 32'(m0_gnt_o),    32'h0);
            check_val("rst_m1_gnt", 32'(m1_gnt_o),    32'h0);
            check_val("rst_m0_rv",  32'(m0_rvalid_o), 32'h0);
            check_val("rst_m1_rv",  32'(m1_rvalid_o), 32'h0);
            check_val("rst_m0_rd",  m0_rdata_o,       32'h0);
            check_val("rst_m1_rd",  m1_rdata_o,       32'h0);
            check_val("rst_err",    32'(err_o),       32'h0);
            check_val("rst_s_addr", s_addr_o,         32'h0);
        end
        q0.delete(); q1.delete(); sb0.delete(); sb1.delete(); pend.delete();
        mcnt = 0; mlast = 1'b1; merr = 1'b0; last0 = 32'h0; last1 = 32'h0;
        inject = 1'b0; stall = 1'b0;
        drive_inputs();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
    endtask

    initial begin
        int exp_order [4];
        arstn_i = 1'b0; s_gnt_i = 1'b1; stall = 1'b0; inject = 1'b0;
        mcnt = 0; mlast = 1'b1; merr = 1'b0; last0 = 32'h0; last1 = 32'h0;
        rd0_last = 32'h0; rv1_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 32'h0101_0101 * i;
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[4] = 32'hCAFE_0001; ref_mem[4] = 32'hCAFE_0001;
        ram_mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
        drive_inputs();
        m0_req_i = 1'b1;
        #2;
        check_val("por_s_req",  32'(s_req_o),  32'h0);
        check_val("por_m0_gnt", 32'(m0_gnt_o), 32'h0);
        check_val("por_m0_rv",  32'(m0_rvalid_o), 32'h0);
        check_val("por_err",    32'(err_o),    32'h0);
        drive_inputs();
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;

        // 1: single m0 read, response two cycles after the grant
        q0.push_back('{we: 1'b0, be: 4'hF, addr: 32'h10, wdata: 32'h0});
        drive_inputs();
        cycle();
        check_val("t1_rv_early", 32'(m0_rvalid_o), 32'h0);
        cycle();
        check_val("t1_rvalid", 32'(m0_rvalid_o), 32'h1);
        check_val("t1_rdata",  m0_rdata_o,       32'hCAFE_0001);
        check_val("t1_m1_rv",  32'(m1_rvalid_o), 32'h0);
        drain();

        // 2: contention from a fresh reset
        do_reset(1'b0);
        order.delete();
        for (int i = 0; i < 3; i++)
            q0.push_back('{we: 1'b0, be: 4'hF, addr: 32'h10 + 32'(4 * i), wdata: 32'h0});
        q1.push_back('{we: 1'b0, be: 4'hF, addr: 32'h1C, wdata: 32'h0});
        drive_inputs();
        drain();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 0};
`else
        exp_order = '{0, 0, 0, 1};
`endif
        check_val("t2_order_len", 32'(order.size()), 32'h4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            check_val("t2_order", 32'(order[i]), 32'(exp_order[i]));

        // 3: m1 partial write, then m0 reads the merged word
        rv1_cnt = 0;
        q1.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h20, wdata: 32'hAABB_CCDD});
        drive_inputs();
        cycle();
        q0.push_back('{we: 1'b0, be: 4'hF, addr: 32'h20, wdata: 32'h0});
        drive_inputs();
        drain();
        check_val("t3_rdata",  rd0_last,     32'h1122_CCDD);
        check_val("t3_m1_rvs", 32'(rv1_cnt), 32'h1);

        // 4: stalled RAM fills the owner FIFO; a response while full frees a slot
        order.delete();
        stall = 1'b1;
        for (int i = 0; i < 5; i++)
            q0.push_back('{we: 1'b0, be: 4'hF, addr: 32'h30 + 32'(4 * i), wdata: 32'h0});
        drive_inputs();
        for (int i = 0; i < 4; i++) cycle();
        check_val("t4_full_grants", 32'(order.size()), 32'h2);
        stall = 1'b0;
        drive_inputs();
        cycle();
        check_val("t4_pop_push", 32'(order.size()), 32'h3);
        s_gnt_i = 1'b0;
        drive_inputs();
        cycle();
        cycle();
        check_val("t4_nognt", 32'(order.size()), 32'h3);
        s_gnt_i = 1'b1;
        drive_inputs();
        drain();

        // 5: stray response sets a sticky error; reset mid-burst clears everything
        for (int i = 0; i < 3; i++) cycle();
        inject = 1'b1;
        drive_inputs();
        cycle();
        inject = 1'b0;
        drive_inputs();
        for (int i = 0; i < 3; i++) cycle();
        check_val("t5_err", 32'(err_o), 32'h1);
        for (int i = 0; i < 3; i++)
            q0.push_back('{we: 1'b0, be: 4'hF, addr: 32'h8 + 32'(4 * i), wdata: 32'h0});
        q1.push_back('{we: 1'b0, be: 4'hF, addr: 32'h4, wdata: 32'h0});
        q1.push_back('{we: 1'b0, be: 4'hF, addr: 32'h10, wdata: 32'h0});
        drive_inputs();
        cycle();
        cycle();
        do_reset(1'b1);
        q1.push_back('{we: 1'b0, be: 4'hF, addr: 32'h10, wdata: 32'h0});
        drive_inputs();
        drain();
        check_val("t5_m1_after", m1_rdata_o, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
